// File: rtl/ballot_pkg.sv
// ballot_pkg: shared types and constants for the ballot controller.
//   state_t    - session FSM states
//   DEF_*      - default parameter values for ballot_controller
//   MAX_CAND   - largest supported candidate count
//   countones  - number of set bits, used to detect multi-press cycles
package ballot_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      LOCK,
      RESULT
   } state_t;

   localparam int unsigned DEF_NUM_CAND   = 4;
   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_DEB_CYCLES = 16;
   localparam int unsigned MAX_CAND       = 16;

   function automatic int unsigned countones(input logic [MAX_CAND-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_CAND; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/ballot_controller_debounce.sv
// btn_debounce: one candidate button channel.
//   clk, rst   - clock, asynchronous active-low reset
//   btn_raw    - raw button, asynchronous to clk
//   level      - debounced level
//   press      - one-cycle pulse on a rising edge of level
// The synchronised button must differ from level for DEB_CYCLES consecutive
// cycles before level follows it; any agreeing cycle restarts the count.
module btn_debounce
   import ballot_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEB_CYCLES);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         // Last of DEB_CYCLES differing cycles: commit the new level.
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: debounced candidate inputs, one-vote-per-ballot session
// FSM, saturating vote counters, display mux and sequential winner/tie scan.
//   clk, rst      - clock, asynchronous active-low reset
//   mode          - 0 voting, 1 result display (synchronised)
//   arm           - officer arm, acts on rising edge (synchronised)
//   cand_btn      - raw candidate buttons
//   disp_sel      - candidate shown on count_out (1-cycle registered)
//   armed         - ballot open
//   vote_ack/rej  - one-cycle accept / multi-press reject pulses
//   count_out     - count of disp_sel, 0 when disp_sel >= NUM_CAND
//   sat           - per-candidate saturated flags
//   winner, tie   - scan result, valid while result_valid
module ballot_controller
   import ballot_pkg::*;
#(
   parameter int unsigned NUM_CAND   = DEF_NUM_CAND,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned IDX_W      = $clog2(NUM_CAND)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic                arm,
   input  logic [NUM_CAND-1:0] cand_btn,
   input  logic [IDX_W-1:0]    disp_sel,
   output logic                armed,
   output logic                vote_ack,
   output logic                vote_rej,
   output logic [CNT_W-1:0]    count_out,
   output logic [NUM_CAND-1:0] sat,
   output logic [IDX_W-1:0]    winner,
   output logic                tie,
   output logic                result_valid
);

   logic [NUM_CAND-1:0] level;
   logic [NUM_CAND-1:0] press;

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
      btn_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(cand_btn[g]),
         .level  (level[g]),
         .press  (press[g])
      );
   end

   logic mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
   logic arm_s1_q,  arm_s1_d,  arm_s2_q,  arm_s2_d;
   logic arm_prev_q, arm_prev_d;
   logic arm_rise;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q [NUM_CAND];
   logic [CNT_W-1:0]      cnt_d [NUM_CAND];
   logic                  ack_q, ack_d;
   logic                  rej_q, rej_d;
   logic [CNT_W-1:0]      count_out_q, count_out_d;
   int unsigned           press_cnt;

   logic                  scanning_q, scanning_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      max_q, max_d;
   logic [IDX_W-1:0]      winner_q, winner_d;
   logic                  tie_q, tie_d;
   logic                  valid_q, valid_d;

   always_comb begin
      mode_s1_d  = mode;
      mode_s2_d  = mode_s1_q;
      arm_s1_d   = arm;
      arm_s2_d   = arm_s1_q;
      arm_prev_d = arm_s2_q;
   end

   assign arm_rise = arm_s2_q & ~arm_prev_q;

   // Session FSM and counters
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      rej_d     = 1'b0;
      press_cnt = countones(MAX_CAND'(press));
      if (mode_s2_q) begin
         state_d = RESULT;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm_rise) state_d = ARMED;
            end
            ARMED: begin
               if (press_cnt == 1) begin
                  ack_d   = 1'b1;
                  state_d = LOCK;
                  for (int unsigned i = 0; i < NUM_CAND; i++) begin
                     if (press[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end else if (press_cnt > 1) begin
                  rej_d = 1'b1;
               end
            end
            LOCK: begin
               if (level == '0) state_d = IDLE;
            end
            RESULT: begin
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Winner scan: one index per cycle after entering RESULT. max starts at 0
   // so an all-zero tally ends with winner 0 and tie set.
   always_comb begin
      scanning_d = scanning_q;
      idx_d      = idx_q;
      max_d      = max_q;
      winner_d   = winner_q;
      tie_d      = tie_q;
      valid_d    = valid_q;
      if ((state_q != RESULT) && (state_d == RESULT)) begin
         scanning_d = 1'b1;
         idx_d      = '0;
         max_d      = '0;
         winner_d   = '0;
         tie_d      = 1'b0;
         valid_d    = 1'b0;
      end else if ((state_q == RESULT) && (state_d != RESULT)) begin
         scanning_d = 1'b0;
         valid_d    = 1'b0;
      end else if (scanning_q) begin
         if (cnt_q[idx_q] > max_q) begin
            max_d    = cnt_q[idx_q];
            winner_d = idx_q;
            tie_d    = 1'b0;
         end else if (cnt_q[idx_q] == max_q) begin
            tie_d = 1'b1;
         end
         if (idx_q == IDX_W'(NUM_CAND - 1)) begin
            scanning_d = 1'b0;
            valid_d    = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      count_out_d = '0;
      if (32'(disp_sel) < NUM_CAND) count_out_d = cnt_q[disp_sel];
   end

   always_comb begin
      sat = '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) sat[i] = (cnt_q[i] == '1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_s1_q   <= 1'b0;
         mode_s2_q   <= 1'b0;
         arm_s1_q    <= 1'b0;
         arm_s2_q    <= 1'b0;
         arm_prev_q  <= 1'b0;
         state_q     <= IDLE;
         for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
         ack_q       <= 1'b0;
         rej_q       <= 1'b0;
         count_out_q <= '0;
         scanning_q  <= 1'b0;
         idx_q       <= '0;
         max_q       <= '0;
         winner_q    <= '0;
         tie_q       <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         mode_s1_q   <= mode_s1_d;
         mode_s2_q   <= mode_s2_d;
         arm_s1_q    <= arm_s1_d;
         arm_s2_q    <= arm_s2_d;
         arm_prev_q  <= arm_prev_d;
         state_q     <= state_d;
         for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= cnt_d[i];
         ack_q       <= ack_d;
         rej_q       <= rej_d;
         count_out_q <= count_out_d;
         scanning_q  <= scanning_d;
         idx_q       <= idx_d;
         max_q       <= max_d;
         winner_q    <= winner_d;
         tie_q       <= tie_d;
         valid_q     <= valid_d;
      end
   end

   assign armed        = (state_q == ARMED);
   assign vote_ack     = ack_q;
   assign vote_rej     = rej_q;
   assign count_out    = count_out_q;
   assign winner       = winner_q;
   assign tie          = tie_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_ballot_controller.sv
module tb_ballot_controller;

   localparam int NC  = 4;
   localparam int CW  = 3;
   localparam int DEB = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mode = 1'b0;
   logic          arm = 1'b0;
   logic [NC-1:0] cand_btn = '0;
   logic [1:0]    disp_sel = '0;
   logic          armed, vote_ack, vote_rej, tie, result_valid;
   logic [CW-1:0] count_out;
   logic [NC-1:0] sat;
   logic [1:0]    winner;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_total = 0;
   int rej_total = 0;
   int model_cnt [NC];

   ballot_controller #(
      .NUM_CAND  (NC),
      .CNT_W     (CW),
      .DEB_CYCLES(DEB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .arm         (arm),
      .cand_btn    (cand_btn),
      .disp_sel    (disp_sel),
      .armed       (armed),
      .vote_ack    (vote_ack),
      .vote_rej    (vote_rej),
      .count_out   (count_out),
      .sat         (sat),
      .winner      (winner),
      .tie         (tie),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (vote_ack === 1'b1) ack_total++;
      if (vote_rej === 1'b1) rej_total++;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; mode = 1'b0; arm = 1'b0; cand_btn = '0;
      tick(2);
      rst = 1'b1;
      tick(2);
      for (int i = 0; i < NC; i++) model_cnt[i] = 0;
   endtask

   task automatic model_vote(input int c);
      if (model_cnt[c] < CMAX) model_cnt[c]++;
   endtask

   task automatic model_result(output int w, output int t);
      int mx, n;
      mx = -1; w = 0; n = 0;
      for (int i = 0; i < NC; i++) if (model_cnt[i] > mx) begin mx = model_cnt[i]; w = i; end
      for (int i = 0; i < NC; i++) if (model_cnt[i] == mx) n++;
      t = (n > 1) ? 1 : 0;
   endtask

   task automatic arm_ballot();
      arm = 1'b1;
      tick(4);
      arm = 1'b0;
      tick(3);
   endtask

   task automatic cast_vote(input int c);
      arm_ballot();
      cand_btn[c] = 1'b1;
      tick(10);
      cand_btn = '0;
      tick(10);
   endtask

   task automatic read_count(input int c, output int v);
      disp_sel = 2'(c);
      tick(1);
      v = int'(count_out);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({armed, vote_ack, vote_rej, tie, result_valid} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {armed, vote_ack, vote_rej, tie, result_valid});
      end
      n_checks++;
      if ({count_out, sat, winner} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", {count_out, sat, winner});
      end
      do_reset();
   endtask

   task automatic test_accept();
      int a0, lat, v;
      a0 = ack_total;
      arm_ballot();
      n_checks++;
      if (armed !== 1'b1) begin n_fail++; $display("FAIL accept_armed: got %b expected 1", armed); end
      cand_btn[2] = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (vote_ack === 1'b1 && lat == 0) lat = i;
      end
      @(negedge clk);
      model_vote(2);
      n_checks++;
      if (lat != 3 + DEB) begin n_fail++; $display("FAIL accept_latency: got %0d expected %0d", lat, 3 + DEB); end
      n_checks++;
      if (ack_total - a0 != 1) begin n_fail++; $display("FAIL accept_acks: got %0d expected 1", ack_total - a0); end
      n_checks++;
      if (armed !== 1'b0) begin n_fail++; $display("FAIL accept_disarm: got %b expected 0", armed); end
      cand_btn = '0;
      tick(10);
      read_count(0, v);
      read_count(2, v);
      n_checks++;
      if (v != model_cnt[2]) begin n_fail++; $display("FAIL accept_count: got %0d expected %0d", v, model_cnt[2]); end
   endtask

   task automatic test_double();
      int a0, v;
      a0 = ack_total;
      arm_ballot();
      cand_btn[2] = 1'b1;
      tick(10);
      model_vote(2);
      cand_btn[3] = 1'b1;     // press in LOCK
      tick(10);
      cand_btn = '0;
      tick(10);
      cand_btn[2] = 1'b1;     // press in IDLE
      tick(10);
      cand_btn = '0;
      tick(10);
      n_checks++;
      if (ack_total - a0 != 1) begin n_fail++; $display("FAIL double_acks: got %0d expected 1", ack_total - a0); end
      read_count(2, v);
      n_checks++;
      if (v != model_cnt[2]) begin n_fail++; $display("FAIL double_count2: got %0d expected %0d", v, model_cnt[2]); end
      read_count(3, v);
      n_checks++;
      if (v != model_cnt[3]) begin n_fail++; $display("FAIL double_count3: got %0d expected %0d", v, model_cnt[3]); end
   endtask

   task automatic test_multi_press();
      int a0, r0, c, v;
      a0 = ack_total; r0 = rej_total;
      arm_ballot();
      cand_btn = 4'b0011;
      tick(10);
      n_checks++;
      if (rej_total - r0 != 1 || ack_total - a0 != 0) begin
         n_fail++; $display("FAIL multi_rej: got rej %0d ack %0d expected rej 1 ack 0", rej_total - r0, ack_total - a0);
      end
      cand_btn = '0;
      tick(10);
      n_checks++;
      if (armed !== 1'b1) begin n_fail++; $display("FAIL multi_still_armed: got %b expected 1", armed); end
      cand_btn[3] = 1'b1;
      tick(3);
      cand_btn = '0;
      tick(10);
      n_checks++;
      if (rej_total - r0 != 1 || ack_total - a0 != 0 || armed !== 1'b1) begin
         n_fail++; $display("FAIL glitch: got rej %0d ack %0d armed %b expected 1 0 1", rej_total - r0, ack_total - a0, armed);
      end
      c = $urandom_range(0, NC - 1);
      cand_btn[c] = 1'b1;
      tick(10);
      cand_btn = '0;
      tick(10);
      model_vote(c);
      n_checks++;
      if (ack_total - a0 != 1 || armed !== 1'b0) begin
         n_fail++; $display("FAIL multi_close: got ack %0d armed %b expected 1 0", ack_total - a0, armed);
      end
      for (int i = 0; i < NC; i++) begin
         read_count(i, v);
         n_checks++;
         if (v != model_cnt[i]) begin n_fail++; $display("FAIL multi_count%0d: got %0d expected %0d", i, v, model_cnt[i]); end
      end
   endtask

   task automatic test_random_votes();
      int a0, c, v;
      logic [NC-1:0] exp_sat;
      for (int k = 0; k < 8; k++) begin
         c = $urandom_range(0, NC - 1);
         a0 = ack_total;
         cast_vote(c);
         model_vote(c);
         n_checks++;
         if (ack_total - a0 != 1) begin n_fail++; $display("FAIL rand_ack%0d: got %0d expected 1", k, ack_total - a0); end
      end
      exp_sat = '0;
      for (int i = 0; i < NC; i++) begin
         read_count(i, v);
         n_checks++;
         if (v != model_cnt[i]) begin n_fail++; $display("FAIL rand_count%0d: got %0d expected %0d", i, v, model_cnt[i]); end
         exp_sat[i] = (model_cnt[i] == CMAX);
      end
      n_checks++;
      if (sat !== exp_sat) begin n_fail++; $display("FAIL rand_sat: got %b expected %b", sat, exp_sat); end
   endtask

   task automatic test_saturation();
      int a0, v;
      do_reset();
      a0 = ack_total;
      for (int k = 0; k < 9; k++) begin
         cast_vote(1);
         model_vote(1);
      end
      n_checks++;
      if (ack_total - a0 != 9) begin n_fail++; $display("FAIL sat_acks: got %0d expected 9", ack_total - a0); end
      read_count(1, v);
      n_checks++;
      if (v != model_cnt[1]) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", v, model_cnt[1]); end
      n_checks++;
      if (sat !== 4'b0010) begin n_fail++; $display("FAIL sat_flags: got %b expected 0010", sat); end
   endtask

   task automatic test_winner(input int c0, input int c1, input int c2, input int c3);
      int want [NC];
      int lat, w, t, a0;
      want = '{c0, c1, c2, c3};
      do_reset();
      for (int i = 0; i < NC; i++)
         for (int k = 0; k < want[i]; k++) begin cast_vote(i); model_vote(i); end
      model_result(w, t);
      mode = 1'b1;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (result_valid === 1'b1 && lat == 0) lat = i;
      end
      @(negedge clk);
      n_checks++;
      if (lat != 3 + NC) begin n_fail++; $display("FAIL win_latency: got %0d expected %0d", lat, 3 + NC); end
      n_checks++;
      if (winner !== 2'(w)) begin n_fail++; $display("FAIL win_index: got %0d expected %0d", winner, w); end
      n_checks++;
      if (tie !== 1'(t)) begin n_fail++; $display("FAIL win_tie: got %b expected %0d", tie, t); end
      a0 = ack_total;
      arm = 1'b1;
      cand_btn[0] = 1'b1;
      tick(10);
      arm = 1'b0;
      cand_btn = '0;
      tick(10);
      n_checks++;
      if (ack_total != a0 || armed !== 1'b0 || winner !== 2'(w) || result_valid !== 1'b1) begin
         n_fail++; $display("FAIL result_hold: got ack %0d armed %b winner %0d valid %b expected 0 0 %0d 1",
                            ack_total - a0, armed, winner, result_valid, w);
      end
      mode = 1'b0;
      tick(5);
      n_checks++;
      if (result_valid !== 1'b0) begin n_fail++; $display("FAIL result_leave: got %b expected 0", result_valid); end
   endtask

   task automatic test_reset_mid();
      int v;
      do_reset();
      cast_vote(3);
      model_vote(3);
      disp_sel = 2'd3;
      mode = 1'b1;
      tick(4);
      n_checks++;
      if (count_out !== 3'd1) begin n_fail++; $display("FAIL midscan_pre: got %0d expected 1", count_out); end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({count_out, sat, winner, tie, result_valid, armed} !== '0) begin
         n_fail++; $display("FAIL midscan_reset: got %h expected 0", {count_out, sat, winner, tie, result_valid, armed});
      end
      tick(1);
      rst = 1'b1; mode = 1'b0;
      tick(3);
      for (int i = 0; i < NC; i++) model_cnt[i] = 0;
      arm_ballot();
      n_checks++;
      if (armed !== 1'b1) begin n_fail++; $display("FAIL midballot_armed: got %b expected 1", armed); end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({armed, vote_ack, vote_rej, count_out} !== '0) begin
         n_fail++; $display("FAIL midballot_reset: got %h expected 0", {armed, vote_ack, vote_rej, count_out});
      end
      tick(1);
      rst = 1'b1;
      tick(2);
      read_count(3, v);
      n_checks++;
      if (v != model_cnt[3]) begin n_fail++; $display("FAIL reset_cleared: got %0d expected %0d", v, model_cnt[3]); end
   endtask

   initial begin
      test_reset();
      test_accept();
      test_double();
      test_multi_press();
      test_random_votes();
      test_saturation();
      test_winner(3, 5, 5, 1);
      test_winner(0, 2, 1, 0);
      test_winner(0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         test_winner($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ballot_controller.md
# ballot_controller

Parametrised successor to the four-candidate voting machine. It supports NUM_CANDIDATES channels with per-channel debounce and an officer-armed one-vote-per-ballot session FSM. Counts saturate instead of wrapping. In result mode a sequential winner/tie scan runs. The block sits between the raw candidate buttons and the LED/display logic, and replaces the separate button-control, vote-count and mode-control instances.

## Interface
- NUM_CAND, 4, number of candidates; legal range 2..16
- CNT_W, 8, width of each vote counter
- DEB_CYCLES, 16, consecutive stable cycles a button needs before its debounced level changes; minimum 2
- IDX_W, $clog2(NUM_CAND), candidate index width (derived; do not override)

- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- mode  in  1  0 = voting, 1 = result display
- arm  in  1  officer arms one ballot; acts on its rising edge
- cand_btn  in  NUM_CAND  raw candidate buttons, active-high, asynchronous to clk
- disp_sel  in  IDX_W  candidate whose count drives count_out
- armed  out  1  ballot open
- vote_ack  out  1  one-cycle pulse: vote accepted
- vote_rej  out  1  one-cycle pulse: vote rejected (multi-press)
- count_out  out  CNT_W  registered count of candidate disp_sel
- sat  out  NUM_CAND  per-candidate counter-saturated flags
- winner  out  IDX_W  index of the highest count
- tie  out  1  two or more candidates share the maximum
- result_valid  out  1  winner and tie are valid

## Operation
- Every input passes through a 2-flop synchroniser.
- Each button then goes through its own debouncer. A rising edge of the debounced level produces a one-cycle press event.
- Session FSM states: IDLE, ARMED, LOCK, RESULT.
  - IDLE -> ARMED on an arm rising edge while mode=0.
  - ARMED, exactly one press event in a cycle: increment that candidate, pulse vote_ack, go to LOCK.
  - ARMED, two or more press events in the same cycle: pulse vote_rej, no count change, stay in ARMED.
  - LOCK -> IDLE once all debounced levels are 0. A new arm is ignored until the FSM reaches IDLE.
  - Any state -> RESULT when mode=1. An open ballot is discarded.
  - RESULT -> IDLE when mode=0. Leaving RESULT clears result_valid.
- armed = 1 only in state ARMED.
- Press events outside ARMED are dropped.
- Counters saturate at 2^CNT_W-1. A vote for a saturated candidate still pulses vote_ack, holds the count, and keeps sat[i]=1.
- Winner scan runs on entry to RESULT:
  - It walks indices 0..NUM_CAND-1, one per cycle, keeping max and winner.
  - A strictly greater count replaces the winner and clears tie. An equal count sets tie.
  - The lowest index wins ties.
  - All counts zero gives winner=0, tie=1.
- count_out is registered from disp_sel in both modes. A disp_sel value ≥ NUM_CAND gives count_out=0.

## Timing
- Reset values:
  - FSM = IDLE; armed = 0, vote_ack = 0, vote_rej = 0
  - all counters = 0, count_out = 0, sat = 0
  - winner = 0, tie = 0, result_valid = 0
  - debouncer levels and stability counters = 0
- Button latency: raw edge -> press event = 2 (sync) + DEB_CYCLES cycles.
- Press event -> counter update and vote_ack: 1 cycle. FSM reaches LOCK in the same cycle.
- disp_sel change -> count_out: 1 cycle.
- mode rising, as seen after sync -> result_valid = 1 after NUM_CAND+1 cycles. winner and tie are stable from then on.
- A press event in the same cycle mode goes to 1 is discarded.
- An arm rising edge in the same cycle as LOCK->IDLE is ignored.
- Reset mid-scan or mid-ballot returns every output to its reset value immediately.

## Structure
- Shared package ballot_pkg holds:
  - state enum {IDLE, ARMED, LOCK, RESULT}
  - default parameter constants
  - a countones helper for multi-press detection
- Sub-module btn_debounce (one instance per channel, via generate):
  - holds the synchroniser, stability counter and debounced level
  - outputs level and press
- The top level holds the FSM, counter array, display mux and winner scan.

## Test plan
- Ballot accept: NUM_CAND=4, DEB_CYCLES=4. Arm, press cand 2 for 10 cycles -> one vote_ack, count[2]=1, armed drops; release -> IDLE.
- Double vote: in LOCK, press cand 2 again without re-arming -> no ack, count[2] stays 1. Press while IDLE -> ignored.
- Multi-press and bounce:
  - cand 0 and 1 rise in the same cycle -> vote_rej, counts unchanged, still ARMED.
  - 3-cycle glitch on cand 3 -> no event.
- Saturation: CNT_W=3, cast 9 votes for cand 1 -> count[1]=7, sat[1]=1, 9 acks.
- Winner/tie:
  - counts {3,5,5,1} -> after mode=1 and NUM_CAND+1 cycles, winner=1, tie=1.
  - counts {0,2,1,0} -> winner=1, tie=0.
- Reset during RESULT scan and during ARMED -> all outputs at reset values on the next sample.
